dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the processor data memory (1024 x 32-bit, word-addressed by address[11:2], synchronous write, combinational read gated by mem_read). Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader. The block accepts one request per transaction, checks alignment and range, and drives the memory strobes for exactly one cycle. It returns read data and an ack or error pulse to the granted port.

Parameters:
DATA_W, 32, data width of requester and memory data buses
ADDR_W, 32, byte address width
MEM_WORDS, 1024, memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous reset, active-low
req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0 or err0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 byte address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 one-cycle completion pulse
err0  out  1  port 0 one-cycle error pulse
req1/we1/addr1/wdata1/ack1/err1  as port 0, for port 1
rdata  out  DATA_W  read data; valid in the cycle when ack0 or ack1 is high for a read
mem_read  out  1  to memory read enable
mem_write  out  1  to memory write enable
mem_address  out  ADDR_W  to memory address
mem_write_data  out  DATA_W  to memory write data
mem_read_data  in  DATA_W  from memory read data

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; ack0=ack1=err0=err1=0; mem_read=mem_write=0; mem_address=0; mem_write_data=0; rdata=0; last_grant=1, so port 0 wins the first tie. Reset overrides everything, including mid-transaction. An in-flight write is not committed, because mem_write is 0 from the reset edge onward.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If any req is high, select a winner and latch its index, we, addr and wdata.
  - Round-robin: on a tie, grant the port other than last_grant. PRIO_MODE=1: on a tie, grant port 0.
  - last_grant updates to the winner.
  - If the latched addr has addr[1:0]!=0 or addr >= 4*MEM_WORDS, go to DONE with an error flag and no memory strobe. Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr; mem_write_data = latched wdata; mem_read = !we; mem_write = we.
  - At the closing edge: a write commits in memory, and a read captures mem_read_data into rdata.
  - Next state is DONE.
- DONE (exactly 1 cycle):
  - ack of the granted port = 1, or err of the granted port = 1 when the error flag is set. ack and err are never high together.
  - Strobes are 0.
  - rdata holds the captured value; it is unchanged on writes and errors.
  - req inputs are ignored. Next state is IDLE.
- Outside ACCESS, mem_read and mem_write are both 0. mem_address and mem_write_data hold their last value.
- Latency: req sampled high in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2. Error latency is 1 cycle (err in cycle k+1).
- Throughput: one access per 3 cycles, or per 2 cycles for errors. A requester that keeps req high after its ack is treated as a new request in the next IDLE.
- Only the granted port ever sees ack or err. The losing port keeps waiting with req held.
- A req that drops before ack (protocol violation) does not abort the latched transaction.

Test Plan:
- Reset → hold rst_n=0 for 2 cycles with req0=req1=1 → all outputs 0. After release, port 0 is granted first.
- Port 0 write then read → write 0xDEADBEEF to addr 0x10, then read 0x10 → mem_write high for exactly 1 cycle with mem_address=0x10; ack0 2 cycles after req; read returns rdata=0xDEADBEEF in the ack0 cycle.
- Continuous contention, PRIO_MODE=0 → req0=req1=1 throughout → ack order 0,1,0,1, with acks 3 cycles apart.
- Fixed priority, PRIO_MODE=1 → same stimulus → only ack0 for 4 transactions; ack1 appears only after req0 drops.
- Errors → port 1 reads addr 0x6 (misaligned), then addr 0x1000 (out of range) → err1 1 cycle after req each time; mem_read and mem_write stay 0; rdata unchanged.
- Reset mid-ACCESS → assert rst_n=0 at the edge ending ACCESS of a write of 0x12345678 to 0x20 → no ack. A later read of 0x20 returns the prior value (0).

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester ports and data-memory strobes seen by the data-memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;

  logic [DATA_W-1:0] rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, err0,
    input  req1, we1, addr1, wdata1,
    output ack1, err1,
    output rdata,
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, err0,
    output req1, we1, addr1, wdata1,
    input  ack1, err1,
    input  rdata,
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory: IDLE picks a winner and
// validates the address, ACCESS strobes memory for one cycle, DONE acks.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int PRIO_MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
    end else if (bus.req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
  end

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    last_grant_d     = last_grant_q;
    we_d             = we_q;
    err_flag_d       = err_flag_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rdata_d          = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d        = win;
          last_grant_d = win;
          we_d         = sel_we;
          // Rejected requests never touch the memory-side address/data.
          if (addr_bad) begin
            err_flag_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_flag_d       = 1'b0;
            mem_address_d    = sel_addr;
            mem_write_data_d = sel_wdata;
            state_d          = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = bus.mem_read_data;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      gnt_q            <= 1'b0;
      last_grant_q     <= 1'b1;
      we_q             <= 1'b0;
      err_flag_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      last_grant_q     <= last_grant_d;
      we_q             <= we_d;
      err_flag_q       <= err_flag_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rdata_q          <= rdata_d;
    end
  end

  // Strobes are gated by rst_n so a reset at the closing ACCESS edge drops the write.
  assign bus.mem_read       = rst_n && (state_q == ACCESS) && !we_q;
  assign bus.mem_write      = rst_n && (state_q == ACCESS) &&  we_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.rdata          = rdata_q;

  assign bus.ack0 = (state_q == DONE) && !err_flag_q && !gnt_q;
  assign bus.ack1 = (state_q == DONE) && !err_flag_q &&  gnt_q;
  assign bus.err0 = (state_q == DONE) &&  err_flag_q && !gnt_q;
  assign bus.err1 = (state_q == DONE) &&  err_flag_q &&  gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin and a fixed-priority instance,
// each with a word memory model; expected responses are queued and matched.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) a ();
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) b ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );
  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
  end
  always @(posedge clk) if (a.mem_write) mem_a[a.mem_address[11:2]] <= a.mem_write_data;
  always @(posedge clk) if (b.mem_write) mem_b[b.mem_address[11:2]] <= b.mem_write_data;
  assign a.mem_read_data = a.mem_read ? mem_a[a.mem_address[11:2]] : 32'h0;
  assign b.mem_read_data = b.mem_read ? mem_b[b.mem_address[11:2]] : 32'h0;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_resp(input int d, input bit port, input bit err, input bit chk_rd,
                             input logic [31:0] rd, input int c);
    exp_t x;
    x.port = port; x.err = err; x.chk_rd = chk_rd; x.rd = rd; x.cyc = c;
    if (d == 0) qa.push_back(x);
    else        qb.push_back(x);
  endtask

  task automatic on_resp(input int d, input logic a0, input logic a1, input logic e0,
                         input logic e1, input logic [31:0] rd);
    exp_t x;
    string p;
    p = (d == 0) ? "rr" : "fp";
    chk({p, "_ack_err_excl"}, 32'((a0 | a1) & (e0 | e1)), 32'h0);
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      chk({p, "_unexpected_resp"}, {28'h0, a0, a1, e0, e1}, 32'h0);
    end else begin
      if (d == 0) x = qa.pop_front();
      else        x = qb.pop_front();
      chk({p, "_resp_port"},  32'(a1 | e1), 32'(x.port));
      chk({p, "_resp_err"},   32'(e0 | e1), 32'(x.err));
      chk({p, "_resp_cycle"}, 32'(cyc),     32'(x.cyc));
      if (x.chk_rd) chk({p, "_resp_rdata"}, rd, x.rd);
      $display("resp %s port=%0d err=%0d rdata=%h cyc=%0d", p, a1 | e1, e0 | e1, rd, cyc);
    end
  endtask

  always @(negedge clk) if (a.ack0 | a.ack1 | a.err0 | a.err1) on_resp(0, a.ack0, a.ack1, a.err0, a.err1, a.rdata);
  always @(negedge clk) if (b.ack0 | b.ack1 | b.err0 | b.err1) on_resp(1, b.ack0, b.ack1, b.err0, b.err1, b.rdata);

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    rst_n = 1'b0;
    a.req0 = 1'b1; a.we0 = 1'b0; a.addr0 = 32'h0; a.wdata0 = 32'h0;
    a.req1 = 1'b1; a.we1 = 1'b0; a.addr1 = 32'h0; a.wdata1 = 32'h0;
    b.req0 = 1'b0; b.we0 = 1'b0; b.addr0 = 32'h0; b.wdata0 = 32'h0;
    b.req1 = 1'b0; b.we1 = 1'b0; b.addr1 = 32'h0; b.wdata1 = 32'h0;

    // Reset held with both requests pending: everything quiet.
    repeat (2) @(negedge clk);
    chk("rst_flags", {26'h0, a.ack0, a.ack1, a.err0, a.err1, a.mem_read, a.mem_write}, 32'h0);
    chk("rst_mem_address", a.mem_address, 32'h0);
    chk("rst_mem_wdata", a.mem_write_data, 32'h0);
    chk("rst_rdata", a.rdata, 32'h0);

    // Port 0 wins the first tie after release.
    c = cyc;
    rst_n = 1'b1;
    expect_resp(0, 1'b0, 1'b0, 1'b1, 32'h0, c + 2);
    expect_resp(0, 1'b1, 1'b0, 1'b1, 32'h0, c + 5);
    wait_until(c + 2); a.req0 = 1'b0;
    wait_until(c + 5); a.req1 = 1'b0;
    @(negedge clk);

    // Port 0 write 0xDEADBEEF to 0x10.
    c = cyc;
    a.req0 = 1'b1; a.we0 = 1'b1; a.addr0 = 32'h10; a.wdata0 = 32'hDEADBEEF;
    expect_resp(0, 1'b0, 1'b0, 1'b0, 32'h0, c + 2);
    @(negedge clk);
    chk("wr_mem_write", 32'(a.mem_write), 32'h1);
    chk("wr_mem_read", 32'(a.mem_read), 32'h0);
    chk("wr_mem_address", a.mem_address, 32'h10);
    chk("wr_mem_wdata", a.mem_write_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_mem_write_done", 32'(a.mem_write), 32'h0);
    a.req0 = 1'b0; a.we0 = 1'b0;
    @(negedge clk);

    // Port 0 read back 0x10.
    c = cyc;
    a.req0 = 1'b1; a.addr0 = 32'h10;
    expect_resp(0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c + 2);
    @(negedge clk);
    chk("rd_mem_read", 32'(a.mem_read), 32'h1);
    chk("rd_mem_write", 32'(a.mem_write), 32'h0);
    chk("rd_mem_address", a.mem_address, 32'h10);
    @(negedge clk);
    a.req0 = 1'b0;
    @(negedge clk);

    // Port 1 misaligned read.
    c = cyc;
    a.req1 = 1'b1; a.addr1 = 32'h6;
    expect_resp(0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, c + 1);
    @(negedge clk);
    chk("err_mis_strobes", {30'h0, a.mem_read, a.mem_write}, 32'h0);
    a.req1 = 1'b0;
    @(negedge clk);

    // Port 1 out-of-range read.
    c = cyc;
    a.req1 = 1'b1; a.addr1 = 32'h1000;
    expect_resp(0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, c + 1);
    @(negedge clk);
    chk("err_oor_strobes", {30'h0, a.mem_read, a.mem_write}, 32'h0);
    chk("err_addr_hold", a.mem_address, 32'h10);
    a.req1 = 1'b0;
    @(negedge clk);

    // Last legal word is accepted.
    c = cyc;
    a.req1 = 1'b1; a.addr1 = 32'hFFC;
    expect_resp(0, 1'b1, 1'b0, 1'b1, 32'h0, c + 2);
    @(negedge clk);
    chk("edge_mem_read", 32'(a.mem_read), 32'h1);
    chk("edge_mem_address", a.mem_address, 32'hFFC);
    @(negedge clk);
    a.req1 = 1'b0;
    @(negedge clk);

    // Continuous contention, round-robin: 0,1,0,1 three cycles apart.
    c = cyc;
    a.req0 = 1'b1; a.addr0 = 32'h10;
    a.req1 = 1'b1; a.addr1 = 32'hFFC;
    expect_resp(0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c + 2);
    expect_resp(0, 1'b1, 1'b0, 1'b1, 32'h0,        c + 5);
    expect_resp(0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c + 8);
    expect_resp(0, 1'b1, 1'b0, 1'b1, 32'h0,        c + 11);
    wait_until(c + 11);
    a.req0 = 1'b0; a.req1 = 1'b0;
    @(negedge clk);

    // Continuous contention, fixed priority: port 1 only after port 0 drops.
    c = cyc;
    b.req0 = 1'b1; b.addr0 = 32'h0;
    b.req1 = 1'b1; b.addr1 = 32'h4;
    expect_resp(1, 1'b0, 1'b0, 1'b1, 32'h0, c + 2);
    expect_resp(1, 1'b0, 1'b0, 1'b1, 32'h0, c + 5);
    expect_resp(1, 1'b0, 1'b0, 1'b1, 32'h0, c + 8);
    expect_resp(1, 1'b0, 1'b0, 1'b1, 32'h0, c + 11);
    expect_resp(1, 1'b1, 1'b0, 1'b1, 32'h0, c + 14);
    wait_until(c + 11); b.req0 = 1'b0;
    wait_until(c + 14); b.req1 = 1'b0;
    @(negedge clk);

    // Reset at the edge closing ACCESS of a write: nothing commits, no ack.
    c = cyc;
    a.req0 = 1'b1; a.we0 = 1'b1; a.addr0 = 32'h20; a.wdata0 = 32'h12345678;
    @(negedge clk);
    chk("mid_mem_write_pre", 32'(a.mem_write), 32'h1);
    rst_n = 1'b0;
    a.req0 = 1'b0; a.we0 = 1'b0;
    #1;
    chk("mid_mem_write_rst", 32'(a.mem_write), 32'h0);
    @(negedge clk);
    chk("mid_no_ack", {30'h0, a.ack0, a.err0}, 32'h0);
    chk("mid_rdata_rst", a.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = cyc;
    a.req0 = 1'b1; a.addr0 = 32'h20;
    expect_resp(0, 1'b0, 1'b0, 1'b1, 32'h0, c + 2);
    @(negedge clk);
    @(negedge clk);
    a.req0 = 1'b0;

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", 32'(qa.size() + qb.size()), 32'h0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
